dcache: RTL and testbench

DCACHE -- requirements
Module: dcache

---
 rtl/dcache_pkg.sv | 16 +
 rtl/dcache_ctrl.sv | 60 ++++++
 rtl/dcache.sv | 124 ++++++++++++
 tb/tb_dcache.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared widths, line geometry and controller state encoding for dcache
package dcache_pkg;
  localparam int OFF_W      = 2;
  localparam int IDX_W      = 3;
  localparam int TAG_W      = 3;
  localparam int BLK_W      = TAG_W + IDX_W;
  localparam int N_LINES    = 1 << IDX_W;
  localparam int LINE_BYTES = 1 << OFF_W;
  localparam int LINE_W     = 8 * LINE_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FETCH     = 2'd2
  } state_e;
endpackage

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - miss-handling FSM and data-memory handshake for dcache
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic hit,
  input  logic victim_dirty,
  input  logic mem_busywait,
  output logic busy,
  output logic hit_done,
  output logic fill,
  output logic mem_read,
  output logic mem_write
);
  state_e state_q, state_d;
  logic   ack_q, ack_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  // ack_q marks the cycle after a hit completes so a held request is not served twice
  always_comb begin
    state_d   = state_q;
    hit_done  = 1'b0;
    fill      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req && !ack_q) begin
          if (hit) hit_done = 1'b1;
          else     state_d  = victim_dirty ? ST_WRITEBACK : ST_FETCH;
        end
      end
      ST_WRITEBACK: begin
        mem_write = 1'b1;
        if (!mem_busywait) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_read = 1'b1;
        if (!mem_busywait) begin
          fill    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ack_d = hit_done;
    busy  = req && !ack_q;
  end
endmodule

// File: rtl/dcache.sv
// rtl/dcache.sv - direct-mapped write-back data cache; DCACHE_STATS_EN adds hit/miss counters
module dcache
  import dcache_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [7:0]        ADDRESS,
  input  logic [7:0]        WRITEDATA,
  output logic [7:0]        READDATA,
  output logic              BUSYWAIT,
  output logic              mem_read,
  output logic              mem_write,
  output logic [BLK_W-1:0]  mem_address,
  output logic [LINE_W-1:0] mem_writedata,
  input  logic [LINE_W-1:0] mem_readdata,
  input  logic              mem_busywait
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);
  logic [TAG_W-1:0]  a_tag;
  logic [IDX_W-1:0]  a_idx;
  logic [OFF_W-1:0]  a_off;
  logic [N_LINES-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_W-1:0]  tag_q  [N_LINES];
  logic [TAG_W-1:0]  tag_d  [N_LINES];
  logic [LINE_W-1:0] data_q [N_LINES];
  logic [LINE_W-1:0] data_d [N_LINES];
  logic hit, busy, hit_done, fill;

  assign a_off = ADDRESS[OFF_W-1:0];
  assign a_idx = ADDRESS[OFF_W +: IDX_W];
  assign a_tag = ADDRESS[OFF_W+IDX_W +: TAG_W];
  assign hit   = valid_q[a_idx] && (tag_q[a_idx] == a_tag);

  dcache_ctrl u_ctrl (
    .clk          (CLK),
    .rst_n        (RESET),
    .req          (READ || WRITE),
    .hit          (hit),
    .victim_dirty (valid_q[a_idx] && dirty_q[a_idx]),
    .mem_busywait (mem_busywait),
    .busy         (busy),
    .hit_done     (hit_done),
    .fill         (fill),
    .mem_read     (mem_read),
    .mem_write    (mem_write)
  );

  assign BUSYWAIT      = RESET && busy;
  assign READDATA      = (RESET && hit) ? data_q[a_idx][{a_off, 3'b000} +: 8] : 8'h00;
  assign mem_writedata = data_q[a_idx];
  assign mem_address   = mem_write ? {tag_q[a_idx], a_idx} : ADDRESS[7:OFF_W];

  // WRITE wins when both strobes are high; a plain read changes nothing
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill) begin
      valid_d[a_idx] = 1'b1;
      dirty_d[a_idx] = 1'b0;
      tag_d[a_idx]   = a_tag;
      data_d[a_idx]  = mem_readdata;
    end
    if (hit_done && WRITE) begin
      data_d[a_idx][{a_off, 3'b000} +: 8] = WRITEDATA;
      dirty_d[a_idx]                      = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;
  logic        miss_pend_q, miss_pend_d;

  // a miss is scored on its closing hit so abandoned fills never count
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    miss_pend_d  = miss_pend_q;
    if (fill) miss_pend_d = 1'b1;
    if (hit_done) begin
      miss_pend_d = 1'b0;
      if (miss_pend_q) begin
        if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
      end else if (hit_count_q != 16'hFFFF) begin
        hit_count_d = hit_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      miss_pend_q  <= 1'b0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      miss_pend_q  <= miss_pend_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif
endmodule

// File: tb/tb_dcache.sv
// tb/tb_dcache.sv - randomized self-checking bench for dcache against a byte-level memory model
module tb_dcache;
  logic        clk = 1'b0;
  logic        RESET, READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, mem_read, mem_write, mem_busywait;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
  int          stat_hit, stat_miss;
`endif

  always #5 clk = ~clk;

  dcache dut (
    .CLK(clk), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  // backing memory and its bookkeeping
  logic [31:0] mem_blk [64];
  int          force_lat = -1;
  int          rd_cyc, wr_cyc, wb_cnt, overlap_err = 0;
  logic [5:0]  wb_addr_l, fetch_addr_l;
  logic [31:0] wb_data_l;

  // reference: latest value of every byte, plus which block each index holds
  logic [7:0]  ref_bytes [256];
  logic        m_valid [8];
  logic        m_dirty [8];
  logic [2:0]  m_tag   [8];

  typedef struct {
    int lat; bit timeout; logic first_busy; logic [7:0] rdata;
    int nwb; logic [5:0] wb_addr; logic [31:0] wb_data;
    int rd_c; int wr_c; logic [5:0] fetch_addr;
  } obs_t;
  typedef struct {
    bit miss; bit wb; logic [5:0] wb_addr; logic [31:0] wb_data; logic [7:0] rdata;
  } exp_t;

  initial begin
    bit   active = 0;
    int   wait_n = 0;
    mem_busywait = 1'b1;
    mem_readdata = '0;
    forever begin
      @(negedge clk);
      if (mem_read && mem_write) overlap_err++;
      if (mem_read || mem_write) begin
        if (mem_read) rd_cyc++; else wr_cyc++;
        if (!active) begin
          active = 1;
          wait_n = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
        end
        if (wait_n == 0) begin
          active       = 0;
          mem_busywait = 1'b0;
          if (mem_read) begin
            mem_readdata = mem_blk[mem_address];
            fetch_addr_l = mem_address;
          end else begin
            mem_blk[mem_address] = mem_writedata;
            wb_addr_l = mem_address;
            wb_data_l = mem_writedata;
            wb_cnt++;
          end
        end else begin
          wait_n--;
          mem_busywait = 1'b1;
          mem_readdata = $urandom;
        end
      end else begin
        active       = 0;
        mem_busywait = 1'b1;
      end
    end
  end

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0;
    end
    for (int b = 0; b < 64; b++)
      for (int j = 0; j < 4; j++) ref_bytes[b*4+j] = mem_blk[b][8*j +: 8];
`ifdef DCACHE_STATS_EN
    stat_hit = 0; stat_miss = 0;
`endif
  endfunction

  function automatic exp_t model_access(input logic wr, input logic [7:0] a, input logic [7:0] d);
    exp_t       e;
    logic [2:0] idx = a[4:2];
    logic [2:0] tg  = a[7:5];
    e.miss    = !(m_valid[idx] && m_tag[idx] == tg);
    e.wb      = e.miss && m_valid[idx] && m_dirty[idx];
    e.wb_addr = {m_tag[idx], idx};
    for (int j = 0; j < 4; j++) e.wb_data[8*j +: 8] = ref_bytes[{m_tag[idx], idx, 2'(j)}];
    if (e.miss) begin
      m_valid[idx] = 1; m_tag[idx] = tg; m_dirty[idx] = 0;
    end
`ifdef DCACHE_STATS_EN
    if (e.miss) stat_miss++; else stat_hit++;
`endif
    e.rdata = ref_bytes[a];
    if (wr) begin
      ref_bytes[a] = d; m_dirty[idx] = 1;
    end
    return e;
  endfunction

  task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, output obs_t o);
    @(negedge clk);
    rd_cyc = 0; wr_cyc = 0; wb_cnt = 0; fetch_addr_l = 'x;
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
    #1;
    o.first_busy = BUSYWAIT;
    o.lat = 0; o.timeout = 1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      o.lat++;
      @(negedge clk);
      if (BUSYWAIT === 1'b0) begin
        o.timeout = 0;
        break;
      end
    end
    o.rdata = READDATA; o.nwb = wb_cnt; o.wb_addr = wb_addr_l; o.wb_data = wb_data_l;
    o.rd_c = rd_cyc; o.wr_c = wr_cyc; o.fetch_addr = fetch_addr_l;
    READ = 0; WRITE = 0;
  endtask

  task automatic test_reset();
    RESET = 0; READ = 1; WRITE = 0; ADDRESS = 8'h05; WRITEDATA = 0;
    repeat (2) @(negedge clk);
    total++; if (BUSYWAIT !== 1'b0) begin bad++; $display("FAIL reset_busywait got=%b want=0", BUSYWAIT); end
    total++; if (READDATA !== 8'h00) begin bad++; $display("FAIL reset_readdata got=%h want=00", READDATA); end
    total++; if ({mem_read, mem_write} !== 2'b00) begin bad++; $display("FAIL reset_memreq got=%b want=00", {mem_read, mem_write}); end
`ifdef DCACHE_STATS_EN
    total++; if ({hit_count, miss_count} !== 32'h0) begin bad++; $display("FAIL reset_stats got=%h want=0", {hit_count, miss_count}); end
`endif
    READ = 0; RESET = 1;
    model_clear();
  endtask

  task automatic test_read_miss_fill();
    obs_t o; exp_t e;
    access(1, 0, 8'h05, 8'h00, o);
    e = model_access(0, 8'h05, 8'h00);
    total++; if (o.first_busy !== 1'b1) begin bad++; $display("FAIL fill_busy_rise got=%b want=1", o.first_busy); end
    total++; if (o.timeout || o.lat != 2 + o.rd_c) begin bad++; $display("FAIL fill_latency got=%0d want=%0d", o.lat, 2 + o.rd_c); end
    total++; if (o.fetch_addr !== 6'h01) begin bad++; $display("FAIL fill_addr got=%h want=01", o.fetch_addr); end
    total++; if (o.rdata !== e.rdata) begin bad++; $display("FAIL fill_rdata got=%h want=%h", o.rdata, e.rdata); end
    total++; if (o.nwb != 0) begin bad++; $display("FAIL fill_no_wb got=%0d want=0", o.nwb); end
  endtask

  task automatic test_write_hit();
    obs_t o; exp_t e;
    access(0, 1, 8'h06, 8'hAB, o);
    e = model_access(1, 8'h06, 8'hAB);
    total++; if (o.timeout || o.lat != 1) begin bad++; $display("FAIL whit_latency got=%0d want=1", o.lat); end
    access(1, 0, 8'h06, 8'h00, o);
    e = model_access(0, 8'h06, 8'h00);
    total++; if (o.lat != 1 || o.rdata !== 8'hAB) begin bad++; $display("FAIL rhit_after_write got=%h/%0d want=ab/1", o.rdata, o.lat); end
  endtask

  task automatic test_evict();
    obs_t o; exp_t e;
    access(1, 0, 8'h26, 8'h00, o);
    e = model_access(0, 8'h26, 8'h00);
    total++; if (o.nwb != 1 || o.wb_addr !== 6'h01) begin bad++; $display("FAIL evict_wb_addr got=%0d/%h want=1/01", o.nwb, o.wb_addr); end
    total++; if (o.wb_data[23:16] !== 8'hAB || o.wb_data !== e.wb_data) begin bad++; $display("FAIL evict_wb_data got=%h want=%h", o.wb_data, e.wb_data); end
    total++; if (o.fetch_addr !== 6'h09) begin bad++; $display("FAIL evict_fetch got=%h want=09", o.fetch_addr); end
    total++; if (o.timeout || o.lat != 2 + o.wr_c + o.rd_c) begin bad++; $display("FAIL evict_latency got=%0d want=%0d", o.lat, 2 + o.wr_c + o.rd_c); end
    total++; if (o.rdata !== e.rdata) begin bad++; $display("FAIL evict_rdata got=%h want=%h", o.rdata, e.rdata); end
  endtask

  task automatic test_read_write_both();
    obs_t o; exp_t e;
`ifdef DCACHE_STATS_EN
    logic [15:0] h0 = hit_count;
`endif
    access(1, 1, 8'h26, 8'h5C, o);
    e = model_access(1, 8'h26, 8'h5C);
    total++; if (o.timeout || o.lat != 1) begin bad++; $display("FAIL rw_latency got=%0d want=1", o.lat); end
`ifdef DCACHE_STATS_EN
    total++; if (hit_count !== h0 + 16'd1) begin bad++; $display("FAIL rw_stats got=%0d want=%0d", hit_count, h0 + 16'd1); end
`endif
    access(1, 0, 8'h26, 8'h00, o);
    e = model_access(0, 8'h26, 8'h00);
    total++; if (o.rdata !== 8'h5C) begin bad++; $display("FAIL rw_written got=%h want=5c", o.rdata); end
  endtask

  task automatic test_reset_abandon();
    obs_t o; exp_t e;
    bit   seen = 0;
    force_lat = 20;
    @(negedge clk);
    READ = 1; ADDRESS = 8'h41;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      seen = (mem_read === 1'b1);
    end
    total++; if (!seen) begin bad++; $display("FAIL abandon_fetch_start got=0 want=1"); end
    @(negedge clk);
    RESET = 0;
    @(negedge clk);
    total++; if (mem_read !== 1'b0 || BUSYWAIT !== 1'b0) begin bad++; $display("FAIL abandon_drop got=%b%b want=00", mem_read, BUSYWAIT); end
    READ = 0; RESET = 1; force_lat = -1;
    model_clear();
    access(1, 0, 8'h41, 8'h00, o);
    e = model_access(0, 8'h41, 8'h00);
    total++; if (o.rd_c == 0 || o.fetch_addr !== 6'h10) begin bad++; $display("FAIL abandon_remiss got=%0d/%h want>0/10", o.rd_c, o.fetch_addr); end
    total++; if (o.rdata !== e.rdata) begin bad++; $display("FAIL abandon_rdata got=%h want=%h", o.rdata, e.rdata); end
  endtask

  task automatic test_random();
    obs_t o; exp_t e;
    int   exp_lat;
    for (int n = 0; n < 250; n++) begin
      logic       rd = 1'($urandom);
      logic       wr = 1'($urandom);
      logic [7:0] a  = 8'($urandom);
      logic [7:0] d  = 8'($urandom);
      if (!rd && !wr) rd = 1;
      access(rd, wr, a, d, o);
      e = model_access(wr, a, d);
      exp_lat = e.miss ? 2 + o.wr_c + o.rd_c : 1;
      total++; if (o.timeout || o.lat != exp_lat || o.first_busy !== 1'b1) begin bad++; $display("FAIL rnd_latency a=%h got=%0d want=%0d", a, o.lat, exp_lat); end
      total++; if (o.nwb != (e.wb ? 1 : 0)) begin bad++; $display("FAIL rnd_wb_count a=%h got=%0d want=%0d", a, o.nwb, e.wb); end
      if (e.wb) begin
        total++; if (o.wb_addr !== e.wb_addr || o.wb_data !== e.wb_data) begin bad++; $display("FAIL rnd_wb a=%h got=%h:%h want=%h:%h", a, o.wb_addr, o.wb_data, e.wb_addr, e.wb_data); end
      end
      if (rd && !wr) begin
        total++; if (o.rdata !== e.rdata) begin bad++; $display("FAIL rnd_rdata a=%h got=%h want=%h", a, o.rdata, e.rdata); end
      end
    end
    total++; if (overlap_err != 0) begin bad++; $display("FAIL mem_rd_wr_overlap got=%0d want=0", overlap_err); end
`ifdef DCACHE_STATS_EN
    total++; if (hit_count !== 16'(stat_hit) || miss_count !== 16'(stat_miss)) begin bad++; $display("FAIL stats got=%0d/%0d want=%0d/%0d", hit_count, miss_count, stat_hit, stat_miss); end
`endif
  endtask

  initial begin
    for (int b = 0; b < 64; b++) mem_blk[b] = $urandom;
    test_reset();
    test_read_miss_fill();
    test_write_hit();
    test_evict();
    test_read_write_both();
    test_reset_abandon();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
